// File: rtl/mem_wait_ctrl_if.sv
// mem_wait_ctrl_if
//   Groups the core-side instruction/data ports and the memory-macro port of
//   the wait-state controller into one bundle.
//   slave  : controller view (requests in, stalls/read data/memory strobes out)
//   master : environment view (core + memory macro), directions reversed
interface mem_wait_ctrl_if;
  // instruction fetch port
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_wait;
  // data port
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_wait;
  // shared memory macro port
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_rdata,
    output imem_rdata, imem_wait, dmem_rdata, dmem_wait,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_rdata,
    input  imem_rdata, imem_wait, dmem_rdata, dmem_wait,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_wait_ctrl.sv
// mem_wait_ctrl
//   Wait-state generator and arbiter between the core's instruction and data
//   ports and one shared single-port memory. Each access is stalled for a
//   fixed number of wait cycles (IMEM_WS / DMEM_WS, 0..15) and then completes
//   with a single mem_en strobe. Data accesses win over fetches when both are
//   requested from idle.
// Ports
//   clk       : system clock, rising edge
//   rst       : asynchronous reset, active low
//   bus       : mem_wait_ctrl_if.slave (imem_*, dmem_*, mem_* signals)
//   stall_cnt : cycles in which either wait output was high, saturating
module mem_wait_ctrl #(
  parameter int unsigned IMEM_WS = 1,
  parameter int unsigned DMEM_WS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_wait_ctrl_if.slave        bus,
  output logic [15:0]           stall_cnt
);

  localparam logic [3:0] IWS = 4'(IMEM_WS);
  localparam logic [3:0] DWS = 4'(DMEM_WS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DBUSY = 2'd1,
    IBUSY = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic [3:0] cnt_next;
  logic       own_d;      // data port owns the memory this cycle
  logic       own_i;      // instruction port owns the memory this cycle
  logic       done;       // completion cycle of the owning access
  logic       imem_wait;
  logic       dmem_wait;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    own_d      = 1'b0;
    own_i      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.dmem_req) begin
          own_d = 1'b1;
          if (DWS == 4'd0) begin
            done = 1'b1;
          end else begin
            // this cycle is the first wait cycle, so DWS-1 remain
            cnt_next   = DWS - 4'd1;
            state_next = DBUSY;
          end
        end else if (bus.imem_req) begin
          own_i = 1'b1;
          if (IWS == 4'd0) begin
            done = 1'b1;
          end else begin
            cnt_next   = IWS - 4'd1;
            state_next = IBUSY;
          end
        end
      end
      DBUSY: begin
        own_d = 1'b1;
        if (!bus.dmem_req) begin
          // requester withdrew: drop the access without touching memory
          cnt_next   = 4'd0;
          state_next = IDLE;
        end else if (cnt == 4'd0) begin
          done       = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      IBUSY: begin
        own_i = 1'b1;
        if (!bus.imem_req) begin
          cnt_next   = 4'd0;
          state_next = IDLE;
        end else if (cnt == 4'd0) begin
          done       = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      default: begin
        cnt_next   = 4'd0;
        state_next = IDLE;
      end
    endcase
  end

  // A port stalls whenever it requests and is not the one completing now,
  // which also covers waiting behind the other port's access.
  assign imem_wait = bus.imem_req & ~(done & own_i);
  assign dmem_wait = bus.dmem_req & ~(done & own_d);

  assign bus.imem_wait  = imem_wait;
  assign bus.dmem_wait  = dmem_wait;
  assign bus.mem_en     = done;
  assign bus.mem_we     = done & own_d & bus.dmem_we;
  assign bus.mem_addr   = own_d ? bus.dmem_addr  :
                          own_i ? bus.imem_addr  : 32'd0;
  assign bus.mem_wdata  = own_d ? bus.dmem_wdata : 32'd0;
  assign bus.imem_rdata = (done & own_i) ? bus.mem_rdata : 32'd0;
  assign bus.dmem_rdata = (done & own_d) ? bus.mem_rdata : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 16'd0;
    end else if ((imem_wait | dmem_wait) && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
